// File: rtl/diff_rx_bank.sv
// diff_rx_bank: WIDTH synchronised differential receivers with glitch filter and error tracking.
// Define EDGE_DET_EN to add the o_rise/o_fall one-cycle edge pulse outputs.
module diff_rx_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_n,
    input  logic             clr_err,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_valid,
    output logic [WIDTH-1:0] err_sticky,
    output logic [CNT_W-1:0] err_cnt
`ifdef EDGE_DET_EN
    ,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
`endif
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam logic [FW:0] FILT_LEN_W = (FW + 1)'(FILT_LEN);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] p_sync_q, p_sync_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] n_sync_q, n_sync_d;
    logic [SYNC_STAGES-1:0]            prime_q, prime_d;
    logic [WIDTH-1:0]                  data_q, data_d;
    logic [WIDTH-1:0]                  cand_q, cand_d;
    logic [WIDTH-1:0]                  valid_q, valid_d;
    logic [WIDTH-1:0]                  sticky_q, sticky_d;
    logic [WIDTH-1:0][FW-1:0]          fcnt_q, fcnt_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [WIDTH-1:0]                  samp, samp_valid, samp_inv;
    logic                              any_inv;

    always_comb begin
        p_sync_d = {p_sync_q[SYNC_STAGES-2:0], i_p};
        n_sync_d = {n_sync_q[SYNC_STAGES-2:0], i_n};
        prime_d  = {prime_q[SYNC_STAGES-2:0], 1'b1};

        samp       = p_sync_q[SYNC_STAGES-1];
        samp_valid = p_sync_q[SYNC_STAGES-1] ^ n_sync_q[SYNC_STAGES-1];
        // The reset contents of the synchroniser are not real samples, so they never count as errors.
        samp_inv   = ~samp_valid & {WIDTH{prime_q[SYNC_STAGES-1]}};
        any_inv    = |samp_inv;
        valid_d    = samp_valid;

        data_d = data_q;
        cand_d = cand_q;
        fcnt_d = fcnt_q;
        for (int k = 0; k < WIDTH; k++) begin
            if (!samp_valid[k] || samp[k] == data_q[k]) begin
                fcnt_d[k] = '0;
            end else if (samp[k] != cand_q[k]) begin
                cand_d[k] = samp[k];
                if (FILT_LEN == 1) begin
                    data_d[k] = samp[k];
                    fcnt_d[k] = '0;
                end else begin
                    fcnt_d[k] = FW'(1);
                end
            end else if ({1'b0, fcnt_q[k]} + (FW + 1)'(1) == FILT_LEN_W) begin
                data_d[k] = samp[k];
                fcnt_d[k] = '0;
            end else begin
                fcnt_d[k] = fcnt_q[k] + FW'(1);
            end
        end

        // A fresh invalid sample wins over a simultaneous clear.
        sticky_d = (clr_err ? '0 : sticky_q) | samp_inv;
        cnt_d    = cnt_q;
        if (clr_err) begin
            cnt_d = CNT_W'(any_inv);
        end else if (any_inv && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_sync_q <= '0;
            n_sync_q <= '0;
            prime_q  <= '0;
            data_q   <= '0;
            cand_q   <= '0;
            valid_q  <= '0;
            sticky_q <= '0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
        end else begin
            p_sync_q <= p_sync_d;
            n_sync_q <= n_sync_d;
            prime_q  <= prime_d;
            data_q   <= data_d;
            cand_q   <= cand_d;
            valid_q  <= valid_d;
            sticky_q <= sticky_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;

`ifdef EDGE_DET_EN
    logic [WIDTH-1:0] prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;

    always_comb begin
        prev_d = data_q;
        rise_d = data_q & ~prev_q;
        fall_d = ~data_q & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;
`endif

endmodule

// File: tb/tb_diff_rx_bank.sv
// Self-checking bench for diff_rx_bank: directed scenarios plus randomised traffic,
// all compared against a sample-history reference model.
module tb_diff_rx_bank;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int F  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  i_p = '0;
    logic [W-1:0]  i_n = '0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  o_data, o_valid, err_sticky;
    logic [CW-1:0] err_cnt;
    logic [W-1:0]  o_rise, o_fall;

    int errors = 0;
    int checks = 0;

    diff_rx_bank #(.WIDTH(W), .SYNC_STAGES(S), .FILT_LEN(F), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .i_p(i_p), .i_n(i_n), .clr_err(clr_err),
        .o_data(o_data), .o_valid(o_valid), .err_sticky(err_sticky), .err_cnt(err_cnt)
`ifdef EDGE_DET_EN
        , .o_rise(o_rise), .o_fall(o_fall)
`endif
    );

`ifndef EDGE_DET_EN
    assign o_rise = '0;
    assign o_fall = '0;
`endif

    always #5 clk = ~clk;

    // Reference model: each input pair reaches the decoder S edges after it is sampled;
    // a channel flips once F consecutive valid samples disagree with its current output.
    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] n;
        logic         live;
    } samp_t;

    samp_t         mq[$];
    logic [W-1:0]  m_data, m_valid, m_sticky, m_prev, m_rise, m_fall;
    logic [CW-1:0] m_cnt;
    int            m_run[W];

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < S; i++) mq.push_back('{p: '0, n: '0, live: 1'b0});
        m_data = '0; m_valid = '0; m_sticky = '0; m_prev = '0;
        m_rise = '0; m_fall = '0; m_cnt = '0;
        for (int k = 0; k < W; k++) m_run[k] = 0;
    endfunction

    function automatic void model_step(input logic [W-1:0] p, input logic [W-1:0] n, input logic clr);
        samp_t        s;
        logic [W-1:0] v, inv;
        s = mq.pop_front();
        mq.push_back('{p: p, n: n, live: 1'b1});
        v   = s.p ^ s.n;
        inv = s.live ? ~v : '0;
        m_rise = m_data & ~m_prev;
        m_fall = ~m_data & m_prev;
        m_prev = m_data;
        for (int k = 0; k < W; k++) begin
            if (!v[k] || s.p[k] == m_data[k]) begin
                m_run[k] = 0;
            end else begin
                m_run[k]++;
                if (m_run[k] == F) begin
                    m_data[k] = s.p[k];
                    m_run[k]  = 0;
                end
            end
        end
        m_valid = v;
        if (clr) begin
            m_sticky = inv;
            m_cnt    = (inv != '0) ? CW'(1) : CW'(0);
        end else begin
            m_sticky = m_sticky | inv;
            if (inv != '0 && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1);
        end
    endfunction

    // Drive one cycle of inputs (called at a negedge), advance the model on the posedge,
    // and return at the following negedge where outputs are sampled.
    task automatic tick(input logic [W-1:0] p, input logic [W-1:0] n, input logic clr);
        i_p = p; i_n = n; clr_err = clr;
        @(posedge clk);
        model_step(p, n, clr);
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic do_reset(input logic [W-1:0] p, input logic [W-1:0] n);
        rst_n = 1'b0; i_p = p; i_n = n; clr_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // Held in reset with a valid pattern, then released: filter latency S+F, o_valid latency S+1.
    task automatic test_reset();
        logic [W-1:0] exp_d, exp_v;
        @(negedge clk);
        checks++;
        if (o_data !== '0 || o_valid !== '0 || err_sticky !== '0 || err_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state got data=%h valid=%h sticky=%h cnt=%0d exp all 0",
                     o_data, o_valid, err_sticky, err_cnt);
        end
        do_reset(8'hFF, 8'h00);
        for (int e = 1; e <= 7; e++) begin
            tick(8'hFF, 8'h00, 1'b0);
            exp_d = (e >= S + F) ? 8'hFF : 8'h00;
            exp_v = (e >= S + 1) ? 8'hFF : 8'h00;
            checks++;
            if (o_data !== exp_d || o_data !== m_data) begin
                errors++;
                $display("[TB] FAIL reset_release_data edge %0d got %h exp %h", e, o_data, exp_d);
            end
            checks++;
            if (o_valid !== exp_v) begin
                errors++;
                $display("[TB] FAIL reset_release_valid edge %0d got %h exp %h", e, o_valid, exp_v);
            end
            checks++;
            if (err_sticky !== '0 || err_cnt !== '0) begin
                errors++;
                $display("[TB] FAIL reset_release_err edge %0d got sticky=%h cnt=%0d exp 0", e, err_sticky, err_cnt);
            end
        end
    endtask

    // Two-cycle dip on ch0 must not reach the output.
    task automatic test_glitch();
        for (int t = 0; t < 8; t++) begin
            if (t < 2) tick(8'hFE, 8'h01, 1'b0);
            else       tick(8'hFF, 8'h00, 1'b0);
            checks++;
            if (o_data !== 8'hFF || err_cnt !== '0) begin
                errors++;
                $display("[TB] FAIL glitch t=%0d got data=%h cnt=%0d exp data=ff cnt=0", t, o_data, err_cnt);
            end
            checks++;
            if (o_valid !== m_valid) begin
                errors++;
                $display("[TB] FAIL glitch_valid t=%0d got %h exp %h", t, o_valid, m_valid);
            end
        end
    endtask

    // Ch3 forced to (1,1) for 4 cycles: output holds, errors recorded.
    task automatic test_invalid_hold();
        int zero_cycles = 0;
        for (int t = 0; t < 10; t++) begin
            if (t < 4) tick(8'hFF, 8'h08, 1'b0);
            else       tick(8'hFF, 8'h00, 1'b0);
            if (!o_valid[3]) zero_cycles++;
            checks++;
            if (o_data !== 8'hFF || o_valid !== m_valid) begin
                errors++;
                $display("[TB] FAIL invalid_hold t=%0d got data=%h valid=%h exp data=ff valid=%h",
                         t, o_data, o_valid, m_valid);
            end
        end
        checks++;
        if (zero_cycles != 4) begin
            errors++;
            $display("[TB] FAIL invalid_hold_valid_low got %0d cycles exp 4", zero_cycles);
        end
        checks++;
        if (err_sticky !== 8'h08 || err_cnt !== 8'd4) begin
            errors++;
            $display("[TB] FAIL invalid_hold_err got sticky=%h cnt=%0d exp sticky=08 cnt=4", err_sticky, err_cnt);
        end
    endtask

    // Long invalid stretch on ch1/ch2 saturates the counter; clear behaviour with and without errors.
    task automatic test_saturate();
        for (int t = 0; t < 300; t++) begin
            tick(8'hFF, 8'h06, 1'b0);
            checks++;
            if (err_cnt !== m_cnt) begin
                errors++;
                $display("[TB] FAIL saturate_cnt t=%0d got %0d exp %0d", t, err_cnt, m_cnt);
            end
        end
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL saturate_final got %0d exp 255", err_cnt);
        end
        tick(8'hFF, 8'h06, 1'b1);
        checks++;
        if (err_cnt !== 8'd1 || err_sticky !== 8'h06) begin
            errors++;
            $display("[TB] FAIL clear_while_invalid got cnt=%0d sticky=%h exp cnt=1 sticky=06", err_cnt, err_sticky);
        end
        for (int t = 0; t < 3; t++) tick(8'hFF, 8'h00, 1'b0);
        checks++;
        if (err_cnt !== m_cnt) begin
            errors++;
            $display("[TB] FAIL drain_cnt got %0d exp %0d", err_cnt, m_cnt);
        end
        tick(8'hFF, 8'h00, 1'b1);
        checks++;
        if (err_cnt !== '0 || err_sticky !== '0) begin
            errors++;
            $display("[TB] FAIL clear_while_valid got cnt=%0d sticky=%h exp 0", err_cnt, err_sticky);
        end
    endtask

    // Ch5 reaches two matching samples, one (0,0) sample restarts the count.
    task automatic test_filter_restart();
        logic [W-1:0] exp_d;
        for (int t = 1; t <= 10; t++) begin
            if (t == 3) tick(8'hDF, 8'h00, 1'b0);
            else        tick(8'hDF, 8'h20, 1'b0);
            exp_d = (t >= 8) ? 8'hDF : 8'hFF;
            checks++;
            if (o_data !== exp_d || o_data !== m_data) begin
                errors++;
                $display("[TB] FAIL filter_restart t=%0d got %h exp %h", t, o_data, exp_d);
            end
        end
    endtask

    // Asynchronous reset between edges clears everything without waiting for a clock.
    task automatic test_reset_midrun();
        for (int t = 0; t < 3; t++) tick(8'hFF, 8'h20, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_data !== '0 || o_valid !== '0 || err_sticky !== '0 || err_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got data=%h valid=%h sticky=%h cnt=%0d exp all 0",
                     o_data, o_valid, err_sticky, err_cnt);
        end
        @(negedge clk);
        do_reset(8'hAA, 8'h55);
        for (int t = 0; t < 6; t++) begin
            tick(8'hAA, 8'h55, 1'b0);
            checks++;
            if (o_data !== m_data || o_valid !== m_valid || err_cnt !== m_cnt) begin
                errors++;
                $display("[TB] FAIL post_reset t=%0d got data=%h valid=%h cnt=%0d exp data=%h valid=%h cnt=%0d",
                         t, o_data, o_valid, err_cnt, m_data, m_valid, m_cnt);
            end
        end
    endtask

    // Random per-channel levels with short pulses, invalid states and occasional clears.
    task automatic test_random();
        logic [W-1:0] lvl, p, n;
        logic         clr;
        int           r;
        lvl = 8'hAA;
        for (int t = 0; t < 600; t++) begin
            for (int k = 0; k < W; k++) begin
                r = $urandom_range(0, 11);
                if (r < 3) lvl[k] = ~lvl[k];
                p[k] = lvl[k];
                n[k] = ~lvl[k];
                if (r == 11) begin
                    p[k] = 1'($urandom_range(0, 1));
                    n[k] = p[k];
                end
            end
            clr = ($urandom_range(0, 39) == 0);
            tick(p, n, clr);
            checks++;
            if (o_data !== m_data) begin
                errors++;
                $display("[TB] FAIL rand_data t=%0d got %h exp %h", t, o_data, m_data);
            end
            checks++;
            if (o_valid !== m_valid) begin
                errors++;
                $display("[TB] FAIL rand_valid t=%0d got %h exp %h", t, o_valid, m_valid);
            end
            checks++;
            if (err_sticky !== m_sticky || err_cnt !== m_cnt) begin
                errors++;
                $display("[TB] FAIL rand_err t=%0d got sticky=%h cnt=%0d exp sticky=%h cnt=%0d",
                         t, err_sticky, err_cnt, m_sticky, m_cnt);
            end
`ifdef EDGE_DET_EN
            checks++;
            if (o_rise !== m_rise || o_fall !== m_fall) begin
                errors++;
                $display("[TB] FAIL rand_edges t=%0d got rise=%h fall=%h exp rise=%h fall=%h",
                         t, o_rise, o_fall, m_rise, m_fall);
            end
`endif
        end
    endtask

`ifdef EDGE_DET_EN
    // Clean 0->1 on ch0: exactly one rise pulse, one cycle after o_data rises; none from reset.
    task automatic test_edge();
        int pulses = 0;
        int t_data = -1;
        int t_rise = -1;
        do_reset(8'h00, 8'hFF);
        for (int t = 0; t < 6; t++) begin
            tick(8'h00, 8'hFF, 1'b0);
            checks++;
            if (o_rise !== '0 || o_fall !== '0) begin
                errors++;
                $display("[TB] FAIL edge_after_reset t=%0d got rise=%h fall=%h exp 0", t, o_rise, o_fall);
            end
        end
        for (int t = 0; t < 10; t++) begin
            tick(8'h01, 8'hFE, 1'b0);
            if (o_data[0] && t_data < 0) t_data = t;
            if (o_rise[0]) begin
                pulses++;
                t_rise = t;
            end
            checks++;
            if (o_rise !== m_rise || o_fall !== '0) begin
                errors++;
                $display("[TB] FAIL edge_rise t=%0d got rise=%h fall=%h exp rise=%h fall=00",
                         t, o_rise, o_fall, m_rise);
            end
        end
        checks++;
        if (pulses != 1 || t_data < 0 || t_rise != t_data + 1) begin
            errors++;
            $display("[TB] FAIL edge_timing got pulses=%0d rise_at=%0d data_at=%0d exp one pulse at data_at+1",
                     pulses, t_rise, t_data);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_invalid_hold();
        test_saturate();
        test_filter_restart();
        test_reset_midrun();
        test_random();
`ifdef EDGE_DET_EN
        test_edge();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
